floo_dma_job_arbiter: RTL and testbench
=======================================

Name: floo_dma_job_arbiter

Overview:
- Shares one iDMA backend job interface (request/response, valid/ready) between NumReq independent job sources inside a DMA test endpoint, e.g. several drivers or a driver plus a config frontend.
- Round-robin arbitrates the request channel and records each granted requester in an in-order tag FIFO.
- Backend responses return in issue order, so each response is routed back to the requester at the FIFO head.
- Also tracks outstanding job count, busy state and protocol errors.

Parameters:
- NumReq, 4, number of requesters; must be >= 1.
- MaxOutstanding, 16, tag FIFO depth = maximum jobs in flight at the backend; must be >= 1.
- idma_req_t, logic, backend job request type; passed through unmodified.
- idma_rsp_t, logic, backend job response type; passed through unmodified.
- IdxWidth, max(1,$clog2(NumReq)), derived requester index width.
- CntWidth, $clog2(MaxOutstanding+1), derived counter width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- pause_i  in  1  when high, no new arbitration starts; a grant already held completes.
- req_i  in  NumReq x idma_req_t  per-requester job.
- req_valid_i  in  NumReq  per-requester valid.
- req_ready_o  out  NumReq  per-requester ready.
- rsp_o  out  NumReq x idma_rsp_t  per-requester response; all lanes carry rsp_i.
- rsp_valid_o  out  NumReq  per-requester response valid.
- rsp_ready_i  in  NumReq  per-requester response ready.
- req_o  out  idma_req_t  job to the backend.
- req_valid_o  out  1  backend request valid.
- req_ready_i  in  1  backend request ready.
- rsp_i  in  idma_rsp_t  backend response.
- rsp_valid_i  in  1  backend response valid.
- rsp_ready_o  out  1  backend response ready.
- outstanding_o  out  CntWidth  jobs issued but not yet answered.
- busy_o  out  1  outstanding_o != 0 or req_valid_o.
- err_o  out  1  sticky protocol error flag.

Behaviour:
- Reset (rst_ni low at a clk_i edge): RR pointer=0, arbiter state=IDLE, tag FIFO empty, outstanding_o=0, err_o=0.
  - During reset, all ready and valid outputs are 0.
  - Reset mid-transfer drops all in-flight tags; the backend must be reset together with this block.
- Arbiter FSM, IDLE:
  - If pause_i=0, FIFO not full and any req_valid_i is set, the winner is the first valid index at or after the RR pointer, cyclically.
  - req_o=req_i[winner], req_valid_o=1, req_ready_o[winner]=req_ready_i, all other lanes' ready=0. This is combinational: zero-cycle latency from requester to backend.
  - Handshake in the same cycle: push winner to FIFO, RR pointer := winner+1 mod NumReq, stay IDLE.
  - No handshake: latch the winner and go to LOCKED.
- Arbiter FSM, LOCKED:
  - Grant held on the latched index regardless of other requesters or pause_i, so valid/payload stability is preserved.
  - On handshake: push, advance pointer, return to IDLE.
  - If the locked requester drops valid before handshake: set err_o, return to IDLE, no push.
- Full: if the FIFO holds MaxOutstanding entries at the start of a cycle, IDLE issues no grant (req_valid_o=0, all req_ready_o=0). A pop in the same cycle does not enable a push; the push is accepted next cycle.
- Response path, FIFO non-empty with head h:
  - rsp_valid_o[h]=rsp_valid_i, other lanes 0.
  - rsp_ready_o=rsp_ready_i[h].
  - Pop on backend handshake.
- Response with FIFO empty: rsp_ready_o=0 and all rsp_valid_o=0; err_o set if rsp_valid_i=1.
- Simultaneous push and pop: FIFO occupancy and outstanding_o unchanged. Otherwise the counter increments on push and decrements on pop; it never wraps.
- err_o clears only on reset.
- NumReq=1: the arbiter degenerates to a pass-through plus tag tracking; the index is always 0.

Test Plan:
- Single job: requester 2 valid, req_ready_i=1 → req_valid_o same cycle, req_ready_o=4'b0100, outstanding_o 0→1; then rsp_valid_i=1 → rsp_valid_o=4'b0100, outstanding_o→0, busy_o→0.
- Fairness: all 4 valid continuously, backend always ready → grant order 0,1,2,3,0,1… with exactly one grant per cycle; responses routed in the same order.
- Lock: requester 1 granted with req_ready_i=0 for 3 cycles while requester 0 also valid → grant stays on 1, req_o stable; the handshake in cycle 4 pushes index 1; the next grant goes to 2 or the wrap, never back to 1 first.
- Full: MaxOutstanding=16, 16 jobs issued without responses → outstanding_o=16, all req_ready_o=0, req_valid_o=0; one response pop → the next push is accepted one cycle later.
- Pause/backpressure: pause_i=1 in IDLE with requests pending → no grant; deassert → grant resumes at the RR pointer. Response held with rsp_ready_i[h]=0 → rsp_ready_o=0 and the FIFO head is unchanged.
- Errors: rsp_valid_i=1 with empty FIFO → err_o=1 sticky, rsp_ready_o=0; locked requester drops valid → err_o=1, no push. Reset mid-flight with 5 outstanding → outstanding_o=0, err_o=0 next cycle.

Source files
------------

// File: rtl/floo_dma_job_arbiter.sv
// rtl/floo_dma_job_arbiter.sv - round-robin sharing of one iDMA backend job port with in-order response routing
module floo_dma_job_arbiter #(
    parameter int unsigned NumReq         = 4,
    parameter int unsigned MaxOutstanding = 16,
    parameter type         idma_req_t     = logic,
    parameter type         idma_rsp_t     = logic,
    parameter int unsigned IdxWidth       = (NumReq > 1) ? $clog2(NumReq) : 1,
    parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                pause_i,
    input  idma_req_t           req_i       [NumReq],
    input  logic [NumReq-1:0]   req_valid_i,
    output logic [NumReq-1:0]   req_ready_o,
    output idma_rsp_t           rsp_o       [NumReq],
    output logic [NumReq-1:0]   rsp_valid_o,
    input  logic [NumReq-1:0]   rsp_ready_i,
    output idma_req_t           req_o,
    output logic                req_valid_o,
    input  logic                req_ready_i,
    input  idma_rsp_t           rsp_i,
    input  logic                rsp_valid_i,
    output logic                rsp_ready_o,
    output logic [CntWidth-1:0] outstanding_o,
    output logic                busy_o,
    output logic                err_o
);

    localparam int unsigned           PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned           SumWidth = IdxWidth + 1;
    localparam logic [IdxWidth-1:0]   LastIdx  = IdxWidth'(NumReq - 1);
    localparam logic [PtrWidth-1:0]   LastPtr  = PtrWidth'(MaxOutstanding - 1);
    localparam logic [CntWidth-1:0]   FullCnt  = CntWidth'(MaxOutstanding);
    localparam logic [SumWidth-1:0]   NumReqW  = SumWidth'(NumReq);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [IdxWidth-1:0] r_rr_ptr;
    logic [IdxWidth-1:0] r_lock_idx;
    logic [IdxWidth-1:0] r_tag_mem [MaxOutstanding];
    logic [PtrWidth-1:0] r_wr_ptr;
    logic [PtrWidth-1:0] r_rd_ptr;
    logic [CntWidth-1:0] r_count;
    logic                r_err;

    logic [2*NumReq-1:0] w_dbl_valid;
    logic [NumReq-1:0]   w_rot_valid;
    logic [IdxWidth-1:0] w_offset;
    logic [SumWidth-1:0] w_sum;
    logic [IdxWidth-1:0] w_rr_winner;
    logic                w_any_valid;
    logic                w_grant_valid;
    logic [IdxWidth-1:0] w_grant_idx;
    logic                w_lock_drop;
    logic                w_full;
    logic                w_empty;
    logic [IdxWidth-1:0] w_head;
    logic                w_push;
    logic                w_pop;
    logic                w_spurious;

    // Rotate the valid vector so bit k is requester (rr_ptr + k) mod NumReq.
    assign w_dbl_valid = {req_valid_i, req_valid_i};
    assign w_rot_valid = w_dbl_valid[r_rr_ptr +: NumReq];

    // First valid requester at or after the round-robin pointer, cyclically.
    always_comb begin
        w_offset    = '0;
        w_any_valid = 1'b0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (w_rot_valid[k]) begin
                w_offset    = IdxWidth'(k);
                w_any_valid = 1'b1;
            end
        end
        w_sum = {1'b0, r_rr_ptr} + {1'b0, w_offset};
        if (w_sum >= NumReqW) begin
            w_sum = w_sum - NumReqW;
        end
        w_rr_winner = w_sum[IdxWidth-1:0];
    end

    assign w_full  = (r_count == FullCnt);
    assign w_empty = (r_count == '0);

    // Arbiter next state and grant selection; a locked grant ignores pause and other lanes.
    always_comb begin
        w_state_next  = r_state;
        w_grant_valid = 1'b0;
        w_grant_idx   = r_lock_idx;
        w_lock_drop   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!pause_i && !w_full && w_any_valid) begin
                    w_grant_valid = 1'b1;
                    w_grant_idx   = w_rr_winner;
                    if (!req_ready_i) begin
                        w_state_next = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (req_valid_i[r_lock_idx]) begin
                    w_grant_valid = 1'b1;
                    if (req_ready_i) begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_lock_drop  = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign req_valid_o = rst_ni & w_grant_valid;
    assign req_o       = req_i[w_grant_idx];
    assign w_push      = req_valid_o & req_ready_i;

    // Only the granted lane sees the backend ready.
    always_comb begin
        req_ready_o = '0;
        if (rst_ni && w_grant_valid) begin
            req_ready_o[w_grant_idx] = req_ready_i;
        end
    end

    assign w_head      = r_tag_mem[r_rd_ptr];
    assign rsp_ready_o = rst_ni & ~w_empty & rsp_ready_i[w_head];
    assign w_pop       = rsp_valid_i & rsp_ready_o;
    assign w_spurious  = rsp_valid_i & w_empty;

    // Responses are steered to the requester whose tag sits at the FIFO head.
    always_comb begin
        rsp_valid_o = '0;
        if (rst_ni && !w_empty) begin
            rsp_valid_o[w_head] = rsp_valid_i;
        end
    end

    for (genvar g = 0; g < NumReq; g++) begin : gen_rsp_fanout
        assign rsp_o[g] = rsp_i;
    end

    // Arbiter state, round-robin pointer and locked index.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_lock_idx <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE && w_state_next == ST_LOCKED) begin
                r_lock_idx <= w_grant_idx;
            end
            if (w_push) begin
                r_rr_ptr <= (w_grant_idx == LastIdx) ? '0 : w_grant_idx + IdxWidth'(1);
            end
        end
    end

    // Tag storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_tag_mem[r_wr_ptr] <= w_grant_idx;
        end
    end

    // Tag FIFO pointers; reset drops every in-flight tag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + PtrWidth'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + PtrWidth'(1);
            end
        end
    end

    // Outstanding count; push is blocked when full and pop needs a tag, so it never wraps.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntWidth'(1);
                2'b01:   r_count <= r_count - CntWidth'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error: spurious response or a locked requester withdrawing its job.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (w_lock_drop || w_spurious) begin
            r_err <= 1'b1;
        end
    end

    assign outstanding_o = r_count;
    assign busy_o        = (r_count != '0) | req_valid_o;
    assign err_o         = r_err;

endmodule

// File: tb/tb_floo_dma_job_arbiter.sv
// tb/tb_floo_dma_job_arbiter.sv - self-checking bench for floo_dma_job_arbiter
module tb_floo_dma_job_arbiter;

    localparam int N    = 4;
    localparam int MAXO = 16;
    typedef logic [15:0] word_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          pause;
    word_t         req_data [N];
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready_lane;
    word_t         rsp_lane [N];
    logic [N-1:0]  rsp_valid_lane;
    logic [N-1:0]  rsp_ready;
    word_t         be_req;
    logic          be_req_valid;
    logic          be_req_ready;
    word_t         be_rsp;
    logic          be_rsp_valid;
    logic          be_rsp_ready;
    logic [4:0]    outstanding;
    logic          busy;
    logic          err;

    int total = 0;
    int bad   = 0;

    floo_dma_job_arbiter #(
        .NumReq        (N),
        .MaxOutstanding(MAXO),
        .idma_req_t    (word_t),
        .idma_rsp_t    (word_t)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .pause_i      (pause),
        .req_i        (req_data),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready_lane),
        .rsp_o        (rsp_lane),
        .rsp_valid_o  (rsp_valid_lane),
        .rsp_ready_i  (rsp_ready),
        .req_o        (be_req),
        .req_valid_o  (be_req_valid),
        .req_ready_i  (be_req_ready),
        .rsp_i        (be_rsp),
        .rsp_valid_i  (be_rsp_valid),
        .rsp_ready_o  (be_rsp_ready),
        .outstanding_o(outstanding),
        .busy_o       (busy),
        .err_o        (err)
    );

    // Reference model: queue of issued requester ids, pointer, lock and error flag.
    int     m_q[$];
    int     m_rr;
    bit     m_locked;
    int     m_lock;
    bit     m_err;
    int     m_grant;
    bit     exp_req_valid;
    logic [N-1:0] exp_req_ready;
    word_t  exp_req_data;
    logic [N-1:0] exp_rsp_valid;
    bit     exp_rsp_ready;
    bit     exp_busy;

    function automatic void model_reset();
        m_q.delete();
        m_rr     = 0;
        m_locked = 1'b0;
        m_lock   = 0;
        m_err    = 1'b0;
    endfunction

    function automatic void model_predict();
        int idx;
        m_grant       = -1;
        exp_req_valid = 1'b0;
        exp_req_ready = '0;
        exp_req_data  = '0;
        exp_rsp_valid = '0;
        exp_rsp_ready = 1'b0;
        if (m_locked) begin
            if (req_valid[m_lock]) m_grant = m_lock;
        end else if (!pause && m_q.size() < MAXO) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (m_grant < 0 && req_valid[idx]) m_grant = idx;
            end
        end
        if (m_grant >= 0) begin
            exp_req_valid          = 1'b1;
            exp_req_ready[m_grant] = be_req_ready;
            exp_req_data           = req_data[m_grant];
        end
        if (m_q.size() > 0) begin
            exp_rsp_valid[m_q[0]] = be_rsp_valid;
            exp_rsp_ready         = rsp_ready[m_q[0]];
        end
        exp_busy = (m_q.size() != 0) || exp_req_valid;
    endfunction

    function automatic void model_update();
        bit push;
        bit pop;
        push = (m_grant >= 0) && be_req_ready;
        pop  = be_rsp_valid && exp_rsp_ready;
        if (m_locked && !req_valid[m_lock]) begin
            m_err    = 1'b1;
            m_locked = 1'b0;
        end else if (m_grant >= 0) begin
            if (push) begin
                m_rr     = (m_grant + 1) % N;
                m_locked = 1'b0;
            end else begin
                m_locked = 1'b1;
                m_lock   = m_grant;
            end
        end
        if (be_rsp_valid && m_q.size() == 0) m_err = 1'b1;
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back(m_grant);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pause        = 1'b0;
        req_valid    = '0;
        be_req_ready = 1'b0;
        be_rsp       = '0;
        be_rsp_valid = 1'b0;
        rsp_ready    = '0;
        for (int i = 0; i < N; i++) req_data[i] = word_t'(16'h1000 + i);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        idle_inputs();
        req_valid    = '1;
        be_req_ready = 1'b1;
        be_rsp_valid = 1'b1;
        rsp_ready    = '1;
        #3;
        total++; if (be_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%0b want=0", be_req_valid); end
        total++; if (req_ready_lane !== 4'b0) begin bad++; $display("FAIL reset_req_ready got=%b want=0000", req_ready_lane); end
        total++; if (rsp_valid_lane !== 4'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0000", rsp_valid_lane); end
        total++; if (be_rsp_ready !== 1'b0) begin bad++; $display("FAIL reset_rsp_ready got=%0b want=0", be_rsp_ready); end
        tick();
        tick();
        total++; if (outstanding !== 5'd0) begin bad++; $display("FAIL reset_outstanding got=%0d want=0", outstanding); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b want=0", err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        rst_n = 1'b1;
        idle_inputs();
    endtask

    task automatic test_single_job();
        do_reset();
        req_valid    = 4'b0100;
        req_data[2]  = 16'hA5A5;
        be_req_ready = 1'b1;
        #3;
        total++; if (be_req_valid !== 1'b1) begin bad++; $display("FAIL single_req_valid got=%0b want=1", be_req_valid); end
        total++; if (req_ready_lane !== 4'b0100) begin bad++; $display("FAIL single_req_ready got=%b want=0100", req_ready_lane); end
        total++; if (be_req !== 16'hA5A5) begin bad++; $display("FAIL single_req_data got=%h want=a5a5", be_req); end
        total++; if (outstanding !== 5'd0) begin bad++; $display("FAIL single_out0 got=%0d want=0", outstanding); end
        tick();
        req_valid    = '0;
        be_req_ready = 1'b0;
        be_rsp_valid = 1'b1;
        be_rsp       = 16'h1234;
        rsp_ready    = 4'b0100;
        #3;
        total++; if (outstanding !== 5'd1) begin bad++; $display("FAIL single_out1 got=%0d want=1", outstanding); end
        total++; if (rsp_valid_lane !== 4'b0100) begin bad++; $display("FAIL single_rsp_valid got=%b want=0100", rsp_valid_lane); end
        total++; if (be_rsp_ready !== 1'b1) begin bad++; $display("FAIL single_rsp_ready got=%0b want=1", be_rsp_ready); end
        total++; if (rsp_lane[2] !== 16'h1234) begin bad++; $display("FAIL single_rsp_data got=%h want=1234", rsp_lane[2]); end
        tick();
        be_rsp_valid = 1'b0;
        #3;
        total++; if (outstanding !== 5'd0) begin bad++; $display("FAIL single_out_end got=%0d want=0", outstanding); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%0b want=0", busy); end
        tick();
    endtask

    task automatic test_fairness();
        logic [N-1:0] want;
        do_reset();
        req_valid    = '1;
        be_req_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            want = 4'b0001 << (k % N);
            #3;
            total++; if (req_ready_lane !== want || be_req_valid !== 1'b1) begin bad++; $display("FAIL fair_grant%0d got=%b want=%b", k, req_ready_lane, want); end
            tick();
        end
        req_valid    = '0;
        be_req_ready = 1'b0;
        be_rsp_valid = 1'b1;
        rsp_ready    = '1;
        for (int k = 0; k < 8; k++) begin
            want = 4'b0001 << (k % N);
            #3;
            total++; if (rsp_valid_lane !== want) begin bad++; $display("FAIL fair_rsp%0d got=%b want=%b", k, rsp_valid_lane, want); end
            tick();
        end
        be_rsp_valid = 1'b0;
        #3;
        total++; if (outstanding !== 5'd0) begin bad++; $display("FAIL fair_drain got=%0d want=0", outstanding); end
        tick();
    endtask

    task automatic test_lock();
        logic [N-1:0] want;
        do_reset();
        req_valid    = 4'b0001;
        be_req_ready = 1'b1;
        tick();
        req_valid    = 4'b0011;
        be_req_ready = 1'b0;
        req_data[0]  = 16'h0F0F;
        req_data[1]  = 16'hBEEF;
        for (int c = 0; c < 3; c++) begin
            pause = (c == 2);
            #3;
            total++; if (be_req_valid !== 1'b1 || be_req !== 16'hBEEF) begin bad++; $display("FAIL lock_hold%0d got=%0b/%h want=1/beef", c, be_req_valid, be_req); end
            tick();
        end
        pause        = 1'b0;
        be_req_ready = 1'b1;
        #3;
        total++; if (req_ready_lane !== 4'b0010) begin bad++; $display("FAIL lock_handshake got=%b want=0010", req_ready_lane); end
        tick();
        req_valid = 4'b0111;
        #3;
        total++; if (req_ready_lane !== 4'b0100) begin bad++; $display("FAIL lock_next got=%b want=0100", req_ready_lane); end
        tick();
        req_valid    = '0;
        be_req_ready = 1'b0;
        be_rsp_valid = 1'b1;
        rsp_ready    = '1;
        for (int k = 0; k < 3; k++) begin
            want = 4'b0001 << k;
            #3;
            total++; if (rsp_valid_lane !== want) begin bad++; $display("FAIL lock_rsp%0d got=%b want=%b", k, rsp_valid_lane, want); end
            tick();
        end
        be_rsp_valid = 1'b0;
    endtask

    task automatic test_full();
        do_reset();
        req_valid    = 4'b0001;
        be_req_ready = 1'b1;
        for (int k = 0; k < MAXO; k++) tick();
        #3;
        total++; if (outstanding !== 5'd16) begin bad++; $display("FAIL full_count got=%0d want=16", outstanding); end
        total++; if (be_req_valid !== 1'b0 || req_ready_lane !== 4'b0) begin bad++; $display("FAIL full_block got=%0b/%b want=0/0000", be_req_valid, req_ready_lane); end
        be_rsp_valid = 1'b1;
        rsp_ready    = '1;
        #1;
        total++; if (req_ready_lane !== 4'b0 || rsp_valid_lane !== 4'b0001) begin bad++; $display("FAIL full_pop_cycle got=%b/%b want=0000/0001", req_ready_lane, rsp_valid_lane); end
        tick();
        be_rsp_valid = 1'b0;
        #3;
        total++; if (req_ready_lane !== 4'b0001 || outstanding !== 5'd15) begin bad++; $display("FAIL full_resume got=%b/%0d want=0001/15", req_ready_lane, outstanding); end
        tick();
        req_valid = '0;
        #3;
        total++; if (outstanding !== 5'd16) begin bad++; $display("FAIL full_refill got=%0d want=16", outstanding); end
        be_rsp_valid = 1'b1;
        for (int k = 0; k < MAXO; k++) tick();
        be_rsp_valid = 1'b0;
        #3;
        total++; if (outstanding !== 5'd0) begin bad++; $display("FAIL full_drain got=%0d want=0", outstanding); end
        tick();
    endtask

    task automatic test_pause_backpressure();
        do_reset();
        pause        = 1'b1;
        req_valid    = 4'b1010;
        be_req_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #3;
            total++; if (be_req_valid !== 1'b0 || req_ready_lane !== 4'b0) begin bad++; $display("FAIL pause_nogrant%0d got=%0b/%b want=0/0000", c, be_req_valid, req_ready_lane); end
            tick();
        end
        pause = 1'b0;
        #3;
        total++; if (req_ready_lane !== 4'b0010) begin bad++; $display("FAIL pause_resume got=%b want=0010", req_ready_lane); end
        tick();
        req_valid    = '0;
        be_rsp_valid = 1'b1;
        rsp_ready    = 4'b1101;
        for (int c = 0; c < 2; c++) begin
            #3;
            total++; if (be_rsp_ready !== 1'b0 || rsp_valid_lane !== 4'b0010 || outstanding !== 5'd1) begin bad++; $display("FAIL bp_hold%0d got=%0b/%b/%0d want=0/0010/1", c, be_rsp_ready, rsp_valid_lane, outstanding); end
            tick();
        end
        rsp_ready = 4'b0010;
        #3;
        total++; if (be_rsp_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%0b want=1", be_rsp_ready); end
        tick();
        be_rsp_valid = 1'b0;
        #3;
        total++; if (outstanding !== 5'd0) begin bad++; $display("FAIL bp_drain got=%0d want=0", outstanding); end
        tick();
    endtask

    task automatic test_errors();
        do_reset();
        be_rsp_valid = 1'b1;
        rsp_ready    = '1;
        #3;
        total++; if (be_rsp_ready !== 1'b0 || rsp_valid_lane !== 4'b0) begin bad++; $display("FAIL err_empty_rsp got=%0b/%b want=0/0000", be_rsp_ready, rsp_valid_lane); end
        tick();
        be_rsp_valid = 1'b0;
        tick();
        tick();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%0b want=1", err); end
        do_reset();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_cleared got=%0b want=0", err); end
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        #3;
        total++; if (be_req_valid !== 1'b0) begin bad++; $display("FAIL err_drop_valid got=%0b want=0", be_req_valid); end
        tick();
        total++; if (err !== 1'b1 || outstanding !== 5'd0) begin bad++; $display("FAIL err_drop got=%0b/%0d want=1/0", err, outstanding); end
        do_reset();
        req_valid    = 4'b0001;
        be_req_ready = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        req_valid    = 4'b0010;
        be_req_ready = 1'b0;
        tick();
        req_valid = '0;
        tick();
        total++; if (err !== 1'b1 || outstanding !== 5'd5) begin bad++; $display("FAIL err_midflight_pre got=%0b/%0d want=1/5", err, outstanding); end
        rst_n = 1'b0;
        tick();
        total++; if (err !== 1'b0 || outstanding !== 5'd0) begin bad++; $display("FAIL err_midflight_reset got=%0b/%0d want=0/0", err, outstanding); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        int lane;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (m_locked && i == m_lock) begin
                    req_valid[i] = 1'b1;
                end else begin
                    req_valid[i] = ($urandom_range(0, 1) == 1);
                    req_data[i]  = word_t'($urandom);
                end
            end
            pause        = ($urandom_range(0, 4) == 0);
            be_req_ready = ($urandom_range(0, 9) < 6);
            be_rsp_valid = (m_q.size() > 0) && ($urandom_range(0, 9) < 4);
            be_rsp       = word_t'($urandom);
            rsp_ready    = N'($urandom);
            model_predict();
            #3;
            lane = $urandom_range(0, N - 1);
            total++; if (be_req_valid !== exp_req_valid) begin bad++; $display("FAIL rnd_req_valid c=%0d got=%0b want=%0b", c, be_req_valid, exp_req_valid); end
            total++; if (req_ready_lane !== exp_req_ready) begin bad++; $display("FAIL rnd_req_ready c=%0d got=%b want=%b", c, req_ready_lane, exp_req_ready); end
            if (exp_req_valid) begin
                total++; if (be_req !== exp_req_data) begin bad++; $display("FAIL rnd_req_data c=%0d got=%h want=%h", c, be_req, exp_req_data); end
            end
            total++; if (rsp_valid_lane !== exp_rsp_valid) begin bad++; $display("FAIL rnd_rsp_valid c=%0d got=%b want=%b", c, rsp_valid_lane, exp_rsp_valid); end
            total++; if (be_rsp_ready !== exp_rsp_ready) begin bad++; $display("FAIL rnd_rsp_ready c=%0d got=%0b want=%0b", c, be_rsp_ready, exp_rsp_ready); end
            total++; if (rsp_lane[lane] !== be_rsp) begin bad++; $display("FAIL rnd_rsp_data c=%0d got=%h want=%h", c, rsp_lane[lane], be_rsp); end
            total++; if (outstanding !== 5'(m_q.size())) begin bad++; $display("FAIL rnd_outstanding c=%0d got=%0d want=%0d", c, outstanding, m_q.size()); end
            total++; if (busy !== exp_busy) begin bad++; $display("FAIL rnd_busy c=%0d got=%0b want=%0b", c, busy, exp_busy); end
            total++; if (err !== m_err) begin bad++; $display("FAIL rnd_err c=%0d got=%0b want=%0b", c, err, m_err); end
            model_update();
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        test_reset();
        test_single_job();
        test_fairness();
        test_lock();
        test_full();
        test_pause_backpressure();
        test_errors();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
